// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default constants for the pipeline stall/kill controller.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DC_WAIT    = 2'd1,
    TRAP_DRAIN = 2'd2
  } pipe_ctrl_state_e;

  typedef enum logic [1:0] {
    PC_NONE   = 2'd0,
    PC_BRANCH = 2'd1,
    PC_TRAP   = 2'd2
  } pc_redirect_e;

  typedef struct packed {
    logic fetch;
    logic dec;
    logic exe;
    logic mem;
  } stall_t;

  typedef struct packed {
    logic fetch;
    logic dec;
    logic exe;
    logic mem;
    logic wb;
  } kill_t;

  localparam int DEF_TRAP_DRAIN_CYCLES = 2;
  localparam int DEF_MISS_TIMEOUT      = 256;
  localparam int DEF_PERF_W            = 32;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/cache/trap inputs and stall/kill/redirect outputs of the pipeline controller.
interface pipeline_ctrl_if #(
  parameter int PERF_W = 32
);
  logic              load_to_use_hazard;
  logic              branch_taken;
  logic              exception_req;
  logic              icache_miss;
  logic              icache_fill_done;
  logic              dcache_miss;
  logic              dcache_fill_done;
  logic              stall_fetch;
  logic              stall_dec;
  logic              stall_exe;
  logic              stall_mem;
  logic              kill_fetch;
  logic              kill_dec;
  logic              kill_exe;
  logic              kill_mem;
  logic              kill_wb;
  logic [1:0]        redirect_sel;
  logic              miss_timeout;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output load_to_use_hazard, branch_taken, exception_req, icache_miss,
           icache_fill_done, dcache_miss, dcache_fill_done,
    input  stall_fetch, stall_dec, stall_exe, stall_mem,
           kill_fetch, kill_dec, kill_exe, kill_mem, kill_wb,
           redirect_sel, miss_timeout, stall_cycles
  );

  modport slave (
    input  load_to_use_hazard, branch_taken, exception_req, icache_miss,
           icache_fill_done, dcache_miss, dcache_fill_done,
    output stall_fetch, stall_dec, stall_exe, stall_mem,
           kill_fetch, kill_dec, kill_exe, kill_mem, kill_wb,
           redirect_sel, miss_timeout, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Enable-gated up counter that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/kill/redirect controller: Mealy decode in RUN, FSM for D-cache miss waits and trap drains.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TRAP_DRAIN_CYCLES = DEF_TRAP_DRAIN_CYCLES,
  parameter int MISS_TIMEOUT      = DEF_MISS_TIMEOUT,
  parameter int PERF_W            = DEF_PERF_W
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);
  localparam int         MC_W       = (MISS_TIMEOUT > 1) ? $clog2(MISS_TIMEOUT) : 1;
  localparam logic [MC_W-1:0] MISS_LAST  = MC_W'(MISS_TIMEOUT - 1);
  localparam logic [3:0] DRAIN_INIT = 4'(TRAP_DRAIN_CYCLES - 1);

  pipe_ctrl_state_e r_state, w_state_next;
  logic             r_ic_outstanding;
  logic [3:0]       r_drain_cnt, w_drain_next;
  logic [MC_W-1:0]  r_miss_cnt, w_miss_next;
  logic             r_miss_timeout, w_timeout_set;
  stall_t           w_stall;
  kill_t            w_kill;
  pc_redirect_e     w_redirect;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state          <= RUN;
      r_ic_outstanding <= 1'b0;
      r_drain_cnt      <= '0;
      r_miss_cnt       <= '0;
      r_miss_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_drain_cnt <= w_drain_next;
      r_miss_cnt  <= w_miss_next;
      if (w_timeout_set) r_miss_timeout <= 1'b1;
      // A new miss outranks a completing fill in the same cycle.
      if (bus.icache_miss)           r_ic_outstanding <= 1'b1;
      else if (bus.icache_fill_done) r_ic_outstanding <= 1'b0;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_drain_next  = r_drain_cnt;
    w_miss_next   = r_miss_cnt;
    w_timeout_set = 1'b0;
    w_stall       = '0;
    w_kill        = '0;
    w_redirect    = PC_NONE;

    case (r_state)
      RUN: begin
        if (bus.exception_req) begin
          w_kill       = '1;
          w_redirect   = PC_TRAP;
          w_state_next = TRAP_DRAIN;
          w_drain_next = DRAIN_INIT;
        end else if (bus.dcache_miss) begin
          w_stall      = '1;
          w_state_next = DC_WAIT;
          w_miss_next  = '0;
        end else if (bus.branch_taken) begin
          w_kill.fetch = 1'b1;
          w_kill.dec   = 1'b1;
          w_redirect   = PC_BRANCH;
        end else if (bus.load_to_use_hazard) begin
          w_stall.fetch = 1'b1;
          w_stall.dec   = 1'b1;
          w_kill.dec    = 1'b1;
        end
      end
      DC_WAIT: begin
        w_stall     = '1;
        w_miss_next = r_miss_cnt + MC_W'(1);
        if (bus.dcache_fill_done) begin
          w_state_next = RUN;
        end else if (r_miss_cnt == MISS_LAST) begin
          w_timeout_set = 1'b1;
          w_kill        = '1;
          w_redirect    = PC_TRAP;
          w_state_next  = TRAP_DRAIN;
          w_drain_next  = DRAIN_INIT;
        end
      end
      TRAP_DRAIN: begin
        w_stall.fetch = 1'b1;
        w_kill        = '1;
        if (r_drain_cnt == 4'd0) w_state_next = RUN;
        else                     w_drain_next = r_drain_cnt - 4'd1;
      end
      default: w_state_next = RUN;
    endcase

    // Outstanding I-cache fill feeds bubbles into decode; the back-end keeps running.
    if (r_ic_outstanding) begin
      w_stall.fetch = 1'b1;
      w_kill.fetch  = 1'b1;
    end

    if (!rst) begin
      w_stall    = '0;
      w_kill     = '0;
      w_redirect = PC_NONE;
    end
  end

  assign bus.stall_fetch  = w_stall.fetch;
  assign bus.stall_dec    = w_stall.dec;
  assign bus.stall_exe    = w_stall.exe;
  assign bus.stall_mem    = w_stall.mem;
  assign bus.kill_fetch   = w_kill.fetch;
  assign bus.kill_dec     = w_kill.dec;
  assign bus.kill_exe     = w_kill.exe;
  assign bus.kill_mem     = w_kill.mem;
  assign bus.kill_wb      = w_kill.wb;
  assign bus.redirect_sel = w_redirect;
  assign bus.miss_timeout = r_miss_timeout;

  sat_counter #(
    .WIDTH (PERF_W)
  ) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst),
    .i_en    (w_stall.dec),
    .o_count (bus.stall_cycles)
  );
endmodule
